// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file access controller:
// sequencer states and the preload table contents.
package rf_ctrl_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    PRELOAD,
    RUN,
    DBG_RD,
    DBG_RESP
  } state_t;

  localparam logic [31:0] SP_INIT   = 32'h0000_0FFF;
  localparam logic [31:0] PAT_BASE  = 32'h0000_0400;
  localparam logic [31:0] NEXT_BASE = 32'h0000_0800;
  localparam logic [31:0] STR_BASE  = 32'h0000_0000;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_STR  = 5'd5;
  localparam logic [4:0] REG_PAT  = 5'd7;
  localparam logic [4:0] REG_NEXT = 5'd11;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_LAST = 5'd31;

  function automatic state_t init_state(input bit clear_en, input bit preload_en);
    if (clear_en)   return CLEAR;
    if (preload_en) return PRELOAD;
    return RUN;
  endfunction

endpackage

// File: rtl/rf_access_ctrl.sv
// Register-file write-port arbiter and init sequencer: clears/preloads the
// register file after reset, then shares the write port and read port 2
// between pipeline write-back and the UART debug requester.
module rf_access_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter bit          CLEAR_ON_INIT = 1'b1,
  parameter bit          PRELOAD_EN    = 1'b1,
  parameter int unsigned STARVE_LIMIT  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        dbg_req,
  input  logic        dbg_wr,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        rf_rsel,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic        cpu_hold,
  output logic        init_done
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic INIT_HOLD = CLEAR_ON_INIT | PRELOAD_EN;

  state_t        state, state_nx;
  logic [4:0]    idx;
  logic [1:0]    pidx;
  logic [SW-1:0] starve, starve_nx;
  logic          wb_valid, dbg_wr_pend, dbg_rd_pend, dbg_grant;

  assign rf_raddr = dbg_addr;

  always_comb begin
    wb_valid    = wb_we && (wb_addr != REG_ZERO);
    // dbg_req is ignored while the ack pulse is out so a held request is not re-serviced.
    dbg_wr_pend = dbg_req && dbg_wr && !dbg_ack;
    dbg_rd_pend = dbg_req && !dbg_wr && !dbg_ack;
    dbg_grant   = (state == RUN) && dbg_wr_pend && !wb_valid;

    starve_nx = '0;
    if ((state == RUN) && dbg_wr_pend && wb_valid)
      starve_nx = (starve == STARVE_MAX) ? starve : starve + SW'(1);

    rf_we    = 1'b0;
    rf_waddr = REG_ZERO;
    rf_wdata = '0;
    state_nx = state;
    case (state)
      CLEAR: begin
        rf_we    = 1'b1;
        rf_waddr = idx;
        if (idx == REG_LAST) begin
          if (PRELOAD_EN) state_nx = PRELOAD;
          else            state_nx = RUN;
        end
      end
      PRELOAD: begin
        rf_we = 1'b1;
        case (pidx)
          2'd0: begin rf_waddr = REG_STR;  rf_wdata = STR_BASE;  end
          2'd1: begin rf_waddr = REG_PAT;  rf_wdata = PAT_BASE;  end
          2'd2: begin rf_waddr = REG_NEXT; rf_wdata = NEXT_BASE; end
          default: begin rf_waddr = REG_SP; rf_wdata = SP_INIT; end
        endcase
        if (pidx == 2'd3) state_nx = RUN;
      end
      default: begin
        // WB forwarding stays live in RUN, DBG_RD and DBG_RESP.
        if (wb_valid) begin
          rf_we    = 1'b1;
          rf_waddr = wb_addr;
          rf_wdata = wb_data;
        end else if (dbg_grant) begin
          rf_we    = (dbg_addr != REG_ZERO);
          rf_waddr = dbg_addr;
          rf_wdata = dbg_wdata;
        end
        case (state)
          RUN:     if (dbg_rd_pend) state_nx = DBG_RD;
          DBG_RD:  state_nx = DBG_RESP;
          default: state_nx = RUN;
        endcase
      end
    endcase
    // Keep the write port quiet while reset is held even though state is already the init state.
    if (!reset) rf_we = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= init_state(CLEAR_ON_INIT, PRELOAD_EN);
      idx       <= 5'd1;
      pidx      <= '0;
      starve    <= '0;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
      init_done <= 1'b0;
      rf_rsel   <= 1'b0;
      cpu_hold  <= INIT_HOLD;
    end else begin
      state  <= state_nx;
      starve <= starve_nx;
      if (state == CLEAR)   idx  <= (idx == REG_LAST) ? 5'd1 : idx + 5'd1;
      if (state == PRELOAD) pidx <= pidx + 2'd1;
      if (state == DBG_RD)  dbg_rdata <= rf_rdata;
      dbg_ack   <= dbg_grant || (state == DBG_RD);
      init_done <= state_nx inside {RUN, DBG_RD, DBG_RESP};
      rf_rsel   <= (state_nx == DBG_RD);
      cpu_hold  <= (state_nx inside {CLEAR, PRELOAD, DBG_RD}) || (starve_nx == STARVE_MAX);
    end
  end

endmodule
